prog_loader: RTL and testbench



---
 rtl/prog_loader_if.sv | 32 +++
 rtl/prog_loader.sv | 185 ++++++++++++++++++
 tb/tb_prog_loader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Boot-loader bus bundle: the incoming word stream plus the imem/dmem write ports.
// The loader takes the master modport; whoever feeds the stream takes the slave modport.
interface prog_loader_if #(
  parameter int INSN_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32,
  parameter int IMEM_AW  = 9
);
  logic                  in_valid;
  logic [31:0]           in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [IMEM_AW-1:0]    imem_addr;
  logic [4*INSN_LEN-1:0] imem_wdata;
  logic                  dmem_we;
  logic [ADDR_LEN-1:0]   dmem_addr;
  logic [DATA_LEN-1:0]   dmem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready,
    output imem_we, imem_addr, imem_wdata,
    output dmem_we, dmem_addr, dmem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready,
    input  imem_we, imem_addr, imem_wdata,
    input  dmem_we, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: reads the header words, packs instructions into 128-bit
// fetch bundles for imem, then writes data words to dmem, holding the core in reset meanwhile.
module prog_loader #(
  parameter int INSN_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32,
  parameter int IMEM_AW  = 9,
  parameter int DMEM_AW  = 10
) (
  input  logic          clk,
  input  logic          reset_x,
  prog_loader_if.master bus,
  output logic          prog_loading,
  output logic          loaded,
  output logic          err
);

  typedef enum logic [2:0] {
    HDR_I, HDR_D, LOAD_I, LOAD_D, DRAIN, DONE, ERR
  } state_e;

  localparam logic [31:0] MaxBundles = 32'd1 << IMEM_AW;
  localparam logic [31:0] MaxWords   = 32'd1 << DMEM_AW;

  state_e                state_q, state_d;
  logic [IMEM_AW:0]      nBundles_q, nBundles_d;
  logic [DMEM_AW:0]      nWords_q, nWords_d;
  logic [IMEM_AW:0]      bundleIdx_q, bundleIdx_d;
  logic [DMEM_AW:0]      wordIdx_q, wordIdx_d;
  logic [1:0]            lane_q, lane_d;
  logic [3*INSN_LEN-1:0] partial_q, partial_d;

  logic                  imemWe_q, imemWe_d;
  logic [IMEM_AW-1:0]    imemAddr_q, imemAddr_d;
  logic [4*INSN_LEN-1:0] imemWdata_q, imemWdata_d;
  logic                  dmemWe_q, dmemWe_d;
  logic [DMEM_AW-1:0]    dmemAddr_q, dmemAddr_d;
  logic [DATA_LEN-1:0]   dmemWdata_q, dmemWdata_d;

  logic                  stateReady;
  logic                  accept;
  logic [IMEM_AW:0]      bundleIdxInc;
  logic [DMEM_AW:0]      wordIdxInc;

  // The async reset parks the FSM in HDR_I, which would otherwise advertise ready during reset.
  assign stateReady   = (state_q == HDR_I) || (state_q == HDR_D) ||
                        (state_q == LOAD_I) || (state_q == LOAD_D);
  assign bus.in_ready = reset_x && stateReady;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bundleIdxInc = bundleIdx_q + (IMEM_AW+1)'(1);
  assign wordIdxInc   = wordIdx_q + (DMEM_AW+1)'(1);

  always_comb begin
    state_d     = state_q;
    nBundles_d  = nBundles_q;
    nWords_d    = nWords_q;
    bundleIdx_d = bundleIdx_q;
    wordIdx_d   = wordIdx_q;
    lane_d      = lane_q;
    partial_d   = partial_q;
    imemWe_d    = 1'b0;
    imemAddr_d  = imemAddr_q;
    imemWdata_d = imemWdata_q;
    dmemWe_d    = 1'b0;
    dmemAddr_d  = dmemAddr_q;
    dmemWdata_d = dmemWdata_q;

    unique case (state_q)
      HDR_I: begin
        if (accept) begin
          if (bus.in_data > MaxBundles) begin
            state_d = ERR;
          end else begin
            nBundles_d = bus.in_data[IMEM_AW:0];
            state_d    = HDR_D;
          end
        end
      end

      HDR_D: begin
        if (accept) begin
          if (bus.in_data > MaxWords) begin
            state_d = ERR;
          end else begin
            nWords_d = bus.in_data[DMEM_AW:0];
            if (nBundles_q != '0) begin
              state_d = LOAD_I;
            end else if (bus.in_data[DMEM_AW:0] != '0) begin
              state_d = LOAD_D;
            end else begin
              state_d = DRAIN;
            end
          end
        end
      end

      LOAD_I: begin
        if (accept) begin
          lane_d = lane_q + 2'd1;
          unique case (lane_q)
            2'd0: partial_d[3*INSN_LEN-1 -: INSN_LEN] = bus.in_data[INSN_LEN-1:0];
            2'd1: partial_d[2*INSN_LEN-1 -: INSN_LEN] = bus.in_data[INSN_LEN-1:0];
            2'd2: partial_d[INSN_LEN-1:0]             = bus.in_data[INSN_LEN-1:0];
            default: begin
              // Lane 3 completes the bundle; the last word goes straight into the write data.
              imemWe_d    = 1'b1;
              imemAddr_d  = bundleIdx_q[IMEM_AW-1:0];
              imemWdata_d = {partial_q, bus.in_data[INSN_LEN-1:0]};
              bundleIdx_d = bundleIdxInc;
              if (bundleIdxInc == nBundles_q) begin
                if (nWords_q != '0) begin
                  state_d = LOAD_D;
                end else begin
                  state_d = DRAIN;
                end
              end
            end
          endcase
        end
      end

      LOAD_D: begin
        if (accept) begin
          dmemWe_d    = 1'b1;
          dmemAddr_d  = wordIdx_q[DMEM_AW-1:0];
          dmemWdata_d = bus.in_data[DATA_LEN-1:0];
          wordIdx_d   = wordIdxInc;
          if (wordIdxInc == nWords_q) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN:   state_d = DONE;
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = HDR_I;
    endcase
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q     <= HDR_I;
      nBundles_q  <= '0;
      nWords_q    <= '0;
      bundleIdx_q <= '0;
      wordIdx_q   <= '0;
      lane_q      <= '0;
      partial_q   <= '0;
      imemWe_q    <= 1'b0;
      imemAddr_q  <= '0;
      imemWdata_q <= '0;
      dmemWe_q    <= 1'b0;
      dmemAddr_q  <= '0;
      dmemWdata_q <= '0;
    end else begin
      state_q     <= state_d;
      nBundles_q  <= nBundles_d;
      nWords_q    <= nWords_d;
      bundleIdx_q <= bundleIdx_d;
      wordIdx_q   <= wordIdx_d;
      lane_q      <= lane_d;
      partial_q   <= partial_d;
      imemWe_q    <= imemWe_d;
      imemAddr_q  <= imemAddr_d;
      imemWdata_q <= imemWdata_d;
      dmemWe_q    <= dmemWe_d;
      dmemAddr_q  <= dmemAddr_d;
      dmemWdata_q <= dmemWdata_d;
    end
  end

  assign bus.imem_we    = imemWe_q;
  assign bus.imem_addr  = imemAddr_q;
  assign bus.imem_wdata = imemWdata_q;
  assign bus.dmem_we    = dmemWe_q;
  assign bus.dmem_addr  = {{(ADDR_LEN-DMEM_AW){1'b0}}, dmemAddr_q};
  assign bus.dmem_wdata = dmemWdata_q;

  assign prog_loading = (state_q != DONE);
  assign loaded       = (state_q == DONE);
  assign err          = (state_q == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a table of image shapes plus random images, each checked
// against write lists built directly from the image contents.
module tb_prog_loader;

  logic clk = 1'b0;
  logic reset_x;
  logic prog_loading, loaded, err;

  prog_loader_if bus ();

  prog_loader dut (
    .clk          (clk),
    .reset_x      (reset_x),
    .bus          (bus),
    .prog_loading (prog_loading),
    .loaded       (loaded),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    ni;
    int    nd;
    int    maxGap;
    bit    expErr;
    int    expI;
    int    expD;
    string tag;
  } vec_t;

  int compareCount = 0;
  int failCount    = 0;
  int overlapCount = 0;
  bit stalled      = 1'b0;

  logic [8:0]   gotIAddr[$];
  logic [127:0] gotIData[$];
  logic [31:0]  gotDAddr[$];
  logic [31:0]  gotDData[$];

  // Every write strobe seen while out of reset is logged for later comparison.
  always @(negedge clk) begin
    if (reset_x) begin
      if (bus.imem_we) begin
        gotIAddr.push_back(bus.imem_addr);
        gotIData.push_back(bus.imem_wdata);
      end
      if (bus.dmem_we) begin
        gotDAddr.push_back(bus.dmem_addr);
        gotDData.push_back(bus.dmem_wdata);
      end
      if (bus.imem_we && bus.dmem_we) overlapCount++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
    end
  endtask

  task automatic clearLogs();
    gotIAddr.delete();
    gotIData.delete();
    gotDAddr.delete();
    gotDData.delete();
    overlapCount = 0;
  endtask

  task automatic doReset();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);
    reset_x = 1'b0;
    stalled = 1'b0;
    #1;
    clearLogs();
    repeat (2) @(negedge clk);
    reset_x = 1'b1;
  endtask

  // Drives one word after 'gap' idle cycles and returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] word, input int gap);
    int waited;
    if (stalled) return;
    repeat (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    waited = 0;
    while (!bus.in_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      stalled = 1'b1;
      checkOutput("accept-timeout in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int pickGap(input int maxGap);
    if (maxGap > 0) return int'($urandom_range(0, maxGap));
    return 0;
  endfunction

  task automatic checkErrorState(input string tag);
    @(negedge clk);
    bus.in_data = $urandom;
    checkOutput({tag, " err"}, err, 1);
    checkOutput({tag, " in_ready"}, bus.in_ready, 0);
    checkOutput({tag, " prog_loading"}, prog_loading, 1);
    checkOutput({tag, " loaded"}, loaded, 0);
    repeat (5) @(negedge clk);
    #1;
    checkOutput({tag, " imem writes"}, gotIAddr.size(), 0);
    checkOutput({tag, " dmem writes"}, gotDAddr.size(), 0);
    checkOutput({tag, " err sticky"}, err, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic streamImage(input int ni, input int nd, input int maxGap,
                             input bit expErr, input int expI, input int expD,
                             input string tag);
    logic [31:0]  words[$];
    logic [8:0]   expIAddr[$];
    logic [127:0] expIData[$];
    logic [31:0]  expDAddr[$];
    logic [31:0]  expDData[$];
    int           nI, nD;

    if (ni <= 512 && nd <= 1024) begin
      for (int i = 0; i < 4*ni + nd; i++) words.push_back($urandom);
      for (int b = 0; b < ni; b++) begin
        expIAddr.push_back(b[8:0]);
        expIData.push_back({words[4*b], words[4*b+1], words[4*b+2], words[4*b+3]});
      end
      for (int d = 0; d < nd; d++) begin
        expDAddr.push_back(d);
        expDData.push_back(words[4*ni + d]);
      end
    end

    applyStimulus(ni, 0);
    if (ni > 512) begin
      checkErrorState(tag);
      checkOutput({tag, " err vs table"}, err, expErr);
      return;
    end
    applyStimulus(nd, pickGap(maxGap));
    if (nd > 1024) begin
      checkErrorState(tag);
      checkOutput({tag, " err vs table"}, err, expErr);
      return;
    end
    foreach (words[i]) applyStimulus(words[i], pickGap(maxGap));

    // The cycle after the final accept shows the last strobe; loaded follows one cycle later.
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput({tag, " drain in_ready"}, bus.in_ready, 0);
    checkOutput({tag, " drain loaded"}, loaded, 0);
    @(negedge clk);
    checkOutput({tag, " done loaded"}, loaded, 1);
    checkOutput({tag, " done prog_loading"}, prog_loading, 0);
    checkOutput({tag, " err vs table"}, err, expErr);
    #1;

    checkOutput({tag, " imem count"}, gotIAddr.size(), expI);
    checkOutput({tag, " dmem count"}, gotDAddr.size(), expD);
    checkOutput({tag, " we overlap"}, overlapCount, 0);
    nI = (gotIAddr.size() < expIAddr.size()) ? gotIAddr.size() : expIAddr.size();
    nD = (gotDAddr.size() < expDAddr.size()) ? gotDAddr.size() : expDAddr.size();
    for (int i = 0; i < nI; i++) begin
      checkOutput($sformatf("%s imem[%0d] addr", tag, i), gotIAddr[i], expIAddr[i]);
      checkOutput($sformatf("%s imem[%0d] data", tag, i), gotIData[i], expIData[i]);
    end
    for (int i = 0; i < nD; i++) begin
      checkOutput($sformatf("%s dmem[%0d] addr", tag, i), gotDAddr[i], expDAddr[i]);
      checkOutput($sformatf("%s dmem[%0d] data", tag, i), gotDData[i], expDData[i]);
    end

    // Once loaded, the stream must be refused and no writes may follow.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      #1;
      checkOutput($sformatf("%s post-done in_ready c%0d", tag, c), bus.in_ready, 0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checkOutput({tag, " post-done imem count"}, gotIAddr.size(), expI);
    checkOutput({tag, " post-done dmem count"}, gotDAddr.size(), expD);
    checkOutput({tag, " post-done loaded"}, loaded, 1);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1,    0,    0, 1'b0, 1,   0,    "n1d0"};
    vecs[1] = '{2,    3,    3, 1'b0, 2,   3,    "n2d3-gaps"};
    vecs[2] = '{0,    0,    0, 1'b0, 0,   0,    "empty"};
    vecs[3] = '{513,  0,    0, 1'b1, 0,   0,    "ni513"};
    vecs[4] = '{0,    1025, 0, 1'b1, 0,   0,    "nd1025"};
    vecs[5] = '{512,  0,    0, 1'b0, 512, 0,    "ni512"};
    vecs[6] = '{0,    1024, 0, 1'b0, 0,   1024, "nd1024"};
    vecs[7] = '{0,    3,    2, 1'b0, 0,   3,    "dataonly"};
    vecs[8] = '{3,    0,    1, 1'b0, 3,   0,    "insnonly"};

    reset_x      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);
    checkOutput("reset in_ready", bus.in_ready, 0);
    checkOutput("reset prog_loading", prog_loading, 1);
    checkOutput("reset loaded", loaded, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset imem_we", bus.imem_we, 0);
    checkOutput("reset imem_addr", bus.imem_addr, 0);
    checkOutput("reset imem_wdata", bus.imem_wdata, 0);
    checkOutput("reset dmem_we", bus.dmem_we, 0);
    checkOutput("reset dmem_addr", bus.dmem_addr, 0);
    checkOutput("reset dmem_wdata", bus.dmem_wdata, 0);
    reset_x = 1'b1;
    @(negedge clk);
    checkOutput("post-reset in_ready", bus.in_ready, 1);

    foreach (vecs[i]) begin
      doReset();
      streamImage(vecs[i].ni, vecs[i].nd, vecs[i].maxGap, vecs[i].expErr,
                  vecs[i].expI, vecs[i].expD, vecs[i].tag);
    end

    // Reset in the middle of a bundle must drop the partial lanes without a strobe.
    doReset();
    applyStimulus(32'd1, 0);
    applyStimulus(32'd0, 0);
    applyStimulus(32'hDEAD_0000, 0);
    applyStimulus(32'hDEAD_0001, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    reset_x = 1'b0;
    #1;
    checkOutput("midreset in_ready", bus.in_ready, 0);
    checkOutput("midreset prog_loading", prog_loading, 1);
    checkOutput("midreset imem_we", bus.imem_we, 0);
    repeat (2) @(negedge clk);
    reset_x = 1'b1;
    checkOutput("midreset no strobe", gotIAddr.size(), 0);
    clearLogs();
    streamImage(1, 0, 0, 1'b0, 1, 0, "midreset-fresh");

    for (int r = 0; r < 6; r++) begin
      int ni, nd;
      ni = int'($urandom_range(0, 4));
      nd = int'($urandom_range(0, 6));
      doReset();
      streamImage(ni, nd, int'($urandom_range(0, 3)), 1'b0, ni, nd,
                  $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
